// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encoding and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wraps modulo 16 for non-decimal digits; such operands are only flagged, never corrected.
    function automatic logic [BCD_DIGIT_W-1:0] nines_comp(input logic [BCD_DIGIT_W-1:0] d);
        return BCD_DIGIT_W'(BCD_MAX) - d;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/busy/done bundle between a requester (master) and the serial BCD adder/subtractor (slave).
interface bcd_serial_addsub_if #(
    parameter int NDIGITS = 4
) ();

    // Handshake: start is accepted only while busy=0; busy covers RUN and DONE; done is a
    // one-cycle pulse and sum/carry_out/invalid are valid from that cycle until the next done.
    logic                   start;
    logic                   sub;
    logic [4*NDIGITS-1:0]   a;
    logic [4*NDIGITS-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   sum;
    logic                   carry_out;
    logic                   invalid;
    bcd_pkg::state_t        dbg_state;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, invalid, dbg_state
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, invalid, dbg_state
    );

endinterface

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit BCD adder: binary add, >9 detect, +6 correction.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_a,
    input  logic [BCD_DIGIT_W-1:0] d_b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] d_s,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] w_t;
    logic [BCD_DIGIT_W:0] w_t_corr;

    assign w_t      = {1'b0, d_a} + {1'b0, d_b} + {{BCD_DIGIT_W{1'b0}}, cin};
    assign w_t_corr = w_t + (BCD_DIGIT_W + 1)'(BCD_CORR);

    always_comb begin
        d_s  = w_t[BCD_DIGIT_W-1:0];
        cout = 1'b0;
        if (w_t > (BCD_DIGIT_W + 1)'(BCD_MAX)) begin
            d_s  = w_t_corr[BCD_DIGIT_W-1:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock LSD first, ten's-complement subtract.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_serial_addsub_if.slave bus
);

    localparam int W     = BCD_DIGIT_W * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W-1:0]           r_work;
    logic [W-1:0]           r_sum;
    logic                   r_sub;
    logic                   r_carry;
    logic                   r_invalid_w;
    logic                   r_done;
    logic                   r_carry_out;
    logic                   r_invalid;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_invalid_in;
    logic [BCD_DIGIT_W-1:0] w_a_dig;
    logic [BCD_DIGIT_W-1:0] w_b_dig;
    logic [BCD_DIGIT_W-1:0] w_bd;
    logic [BCD_DIGIT_W-1:0] w_digit;
    logic                   w_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_invalid_in = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX)) ||
                (bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))) begin
                w_invalid_in = 1'b1;
            end
        end
    end

    // The single digit cell is time-shared: r_idx selects the operand digit pair each RUN cycle.
    assign w_a_dig = r_a[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign w_b_dig = r_b[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign w_bd    = r_sub ? nines_comp(w_b_dig) : w_b_dig;

    bcd_digit_cell u_cell (
        .d_a  (w_a_dig),
        .d_b  (w_bd),
        .cin  (r_carry),
        .d_s  (w_digit),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_work      <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_invalid_w <= 1'b0;
            r_done      <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a         <= bus.a;
                r_b         <= bus.b;
                r_sub       <= bus.sub;
                r_carry     <= bus.sub;
                r_idx       <= '0;
                r_invalid_w <= w_invalid_in;
            end else if (r_state == ST_RUN) begin
                r_work[int'(r_idx)*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_digit;
                r_carry <= w_cout;
                if (!w_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end else if (r_state == ST_DONE) begin
                r_done      <= 1'b1;
                r_sum       <= r_work;
                r_carry_out <= r_carry;
                r_invalid   <= r_invalid_w;
            end
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.invalid   = r_invalid;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: vector table plus hand sequences for handshake, reset and NDIGITS=1.
module tb_bcd_serial_addsub;

    logic clk;
    logic rst_n;

    bcd_serial_addsub_if #(.NDIGITS(4)) bus4 ();
    bcd_serial_addsub_if #(.NDIGITS(1)) bus1 ();

    bcd_serial_addsub #(.NDIGITS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    bcd_serial_addsub #(.NDIGITS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic        inv;
    } vec_t;

    int          n_checks;
    int          n_errors;
    logic [15:0] last_sum;
    vec_t        vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Starts one op on the 4-digit unit and checks busy, latency, results and single-cycle done.
    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] esum, input logic ec, input logic ei, input string nm);
        int k;
        bit moved;
        moved = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.sub   = s;
        bus4.a     = a;
        bus4.b     = b;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        chk({nm, "_busy"}, 32'(bus4.busy), 32'd1);
        k = 0;
        while (k < 12) begin
            @(posedge clk);
            #1;
            k++;
            if (bus4.done) break;
            if (bus4.sum !== last_sum) moved = 1'b1;
        end
        chk({nm, "_latency"}, 32'(k), 32'd5);
        chk({nm, "_sum"}, 32'(bus4.sum), 32'(esum));
        chk({nm, "_cout"}, 32'(bus4.carry_out), 32'(ec));
        chk({nm, "_inv"}, 32'(bus4.invalid), 32'(ei));
        chk({nm, "_hold"}, 32'(moved), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_done_pulse"}, 32'(bus4.done), 32'd0);
        last_sum = esum;
    endtask

    initial begin
        int n_done;
        int dk;
        int de[4];
        logic [15:0] dsum;

        n_checks   = 0;
        n_errors   = 0;
        last_sum   = 16'h0000;
        rst_n      = 1'b0;
        bus4.start = 1'b0;
        bus4.sub   = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus1.start = 1'b0;
        bus1.sub   = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;

        vecs[0]  = '{1'b0, 16'h0004, 16'h0004, 16'h0008, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0009, 16'h0004, 16'h0013, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 16'h0003, 16'h0005, 16'h9998, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'h1000, 16'h0001, 16'h0999, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h000A, 16'h0001, 16'h0011, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h5678, 16'h4567, 16'h0245, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_sum", 32'(bus4.sum), 32'd0);
        chk("rst_cout", 32'(bus4.carry_out), 32'd0);
        chk("rst_inv", 32'(bus4.invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].inv,
                   $sformatf("v%0d", i));
        end

        // Starts during RUN (k=2) and DONE (k=5) must be dropped.
        n_done = 0;
        dk     = -1;
        dsum   = '0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            bus4.start = (k == 0 || k == 2 || k == 5);
            if (k == 0) begin
                bus4.sub = 1'b0;
                bus4.a   = 16'h1234;
                bus4.b   = 16'h4321;
            end else if (k == 2 || k == 5) begin
                bus4.a = 16'h1111;
                bus4.b = 16'h1111;
            end
            @(posedge clk);
            #1;
            if (bus4.done) begin
                n_done++;
                dk   = k;
                dsum = bus4.sum;
            end
            if (k == 5) chk("ign_busy_after_done", 32'(bus4.busy), 32'd0);
        end
        bus4.start = 1'b0;
        chk("ign_done_count", 32'(n_done), 32'd1);
        chk("ign_done_edge", 32'(dk), 32'd5);
        chk("ign_sum", 32'(dsum), 32'h5555);

        // Start held high: one op every six cycles.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.sub   = 1'b0;
        bus4.a     = 16'h0004;
        bus4.b     = 16'h0004;
        n_done     = 0;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            if (bus4.done) begin
                if (n_done < 4) de[n_done] = k;
                n_done++;
            end
        end
        @(negedge clk);
        bus4.start = 1'b0;
        chk("b2b_count", 32'(n_done), 32'd3);
        if (n_done >= 3) begin
            chk("b2b_gap1", 32'(de[1] - de[0]), 32'd6);
            chk("b2b_gap2", 32'(de[2] - de[1]), 32'd6);
        end
        last_sum = 16'h0008;

        run_op(1'b0, 16'h5000, 16'h6000, 16'h1000, 1'b1, 1'b0, "pre_rst");

        // Reset asserted for one edge two cycles into RUN.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = 16'h9999;
        bus4.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(bus4.busy), 32'd0);
        chk("mid_rst_sum", 32'(bus4.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus4.carry_out), 32'd0);
        chk("mid_rst_done", 32'(bus4.done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus4.done) n_done++;
        end
        chk("mid_rst_no_done", 32'(n_done), 32'd0);
        last_sum = 16'h0000;

        run_op(1'b0, 16'h0500, 16'h0500, 16'h1000, 1'b0, 1'b0, "post_rst");

        // Single-digit unit: 7+5 -> 2 carry 1, done two edges after the start edge.
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.sub   = 1'b0;
        bus1.a     = 4'h7;
        bus1.b     = 4'h5;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        dk = 0;
        while (dk < 10) begin
            @(posedge clk);
            #1;
            dk++;
            if (bus1.done) break;
        end
        chk("n1_latency", 32'(dk), 32'd2);
        chk("n1_sum", 32'(bus1.sum), 32'h2);
        chk("n1_cout", 32'(bus1.carry_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
